// File: rtl/galaxian_dl_pkg.sv
// galaxian_dl_pkg: shared state encoding, ROM region map and region select codes.
package galaxian_dl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLDOFF,
        ST_RUN
    } state_t;

    localparam logic [15:0] PROG_BASE  = 16'h0000;
    localparam logic [15:0] PROG_LIMIT = 16'h3FFF;
    localparam logic [15:0] GFX_BASE   = 16'h4000;
    localparam logic [15:0] GFX_LIMIT  = 16'h4FFF;
    localparam logic [15:0] PAL_BASE   = 16'h5000;
    localparam logic [15:0] PAL_LIMIT  = 16'h501F;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_PROG = 3'b001;
    localparam logic [2:0] SEL_GFX  = 3'b010;
    localparam logic [2:0] SEL_PAL  = 3'b100;

endpackage

// File: rtl/galaxian_dl_ctrl_if.sv
// galaxian_dl_ctrl_if: download stream, CPU read handshake, shared ROM port and status.
interface galaxian_dl_ctrl_if;

    logic        dl_active;
    logic        dl_wr;
    logic [15:0] dl_addr;
    logic [7:0]  dl_data;
    logic        cpu_rd_req;
    logic [13:0] cpu_addr;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [2:0]  mem_sel;
    logic        cpu_rd_ack;
    logic        cpu_hold;
    logic        core_reset;
    logic        dl_done;
    logic        dl_error;
    logic [7:0]  dl_sum;

    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data, cpu_rd_req, cpu_addr,
        output mem_addr, mem_wdata, mem_we, mem_sel, cpu_rd_ack, cpu_hold,
               core_reset, dl_done, dl_error, dl_sum
    );

    modport master (
        output dl_active, dl_wr, dl_addr, dl_data, cpu_rd_req, cpu_addr,
        input  mem_addr, mem_wdata, mem_we, mem_sel, cpu_rd_ack, cpu_hold,
               core_reset, dl_done, dl_error, dl_sum
    );

endinterface

// File: rtl/galaxian_dl_decode.sv
// galaxian_dl_decode: maps a download address to a region select and region-relative address.
module galaxian_dl_decode
    import galaxian_dl_pkg::*;
(
    input  logic [15:0] i_addr,
    output logic [2:0]  o_sel,
    output logic [15:0] o_rel,
    output logic        o_oor
);

    logic w_prog;
    logic w_gfx;
    logic w_pal;

    assign w_prog = i_addr <= PROG_LIMIT;
    assign w_gfx  = (i_addr >= GFX_BASE) && (i_addr <= GFX_LIMIT);
    assign w_pal  = (i_addr >= PAL_BASE) && (i_addr <= PAL_LIMIT);

    assign o_sel = w_prog ? SEL_PROG : w_gfx ? SEL_GFX : w_pal ? SEL_PAL : SEL_NONE;
    assign o_rel = w_gfx ? i_addr - GFX_BASE : w_pal ? i_addr - PAL_BASE : i_addr - PROG_BASE;
    assign o_oor = ~(w_prog | w_gfx | w_pal);

endmodule

// File: rtl/galaxian_dl_ctrl.sv
// galaxian_dl_ctrl: ROM download sequencer that owns the shared ROM port and holds the core in reset.
// Optional feature: define DL_CHECKSUM_EN to accumulate a mod-256 byte sum on dl_sum.
module galaxian_dl_ctrl
    import galaxian_dl_pkg::*;
#(
    parameter int          HOLDOFF_CYCLES = 16,
    parameter logic [15:0] EXPECTED_LEN   = 16'h5020
) (
    input logic               clk_sys,
    input logic               reset,
    galaxian_dl_ctrl_if.slave bus
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_hold_cnt;
    logic [15:0] r_byte_cnt;
    logic [15:0] w_cnt_nxt;
    logic        r_done;
    logic        r_error;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic        r_mem_we;
    logic [2:0]  r_mem_sel;
    logic        r_rd_ack;
    logic [2:0]  w_sel;
    logic [15:0] w_rel;
    logic        w_oor;
    logic        w_wr;
    logic        w_accept;
    logic        w_load_entry;
    logic        w_load_exit;
    logic        w_hold_entry;
    logic        w_run_entry;

    galaxian_dl_decode u_decode (
        .i_addr (bus.dl_addr),
        .o_sel  (w_sel),
        .o_rel  (w_rel),
        .o_oor  (w_oor)
    );

    assign w_wr         = (r_state == ST_LOAD) && bus.dl_wr;
    assign w_accept     = w_wr && !w_oor;
    assign w_cnt_nxt    = (w_accept && r_byte_cnt != 16'hFFFF) ? r_byte_cnt + 16'd1 : r_byte_cnt;
    assign w_load_entry = (r_state != ST_LOAD) && (w_state_nxt == ST_LOAD);
    assign w_load_exit  = (r_state == ST_LOAD) && (w_state_nxt != ST_LOAD);
    assign w_hold_entry = (r_state != ST_HOLDOFF) && (w_state_nxt == ST_HOLDOFF);
    assign w_run_entry  = (r_state != ST_RUN) && (w_state_nxt == ST_RUN);

    // Next state: a rising download always wins; holdoff ends when its counter runs out.
    always_comb begin
        w_state_nxt = (r_state == ST_LOAD) ? (bus.dl_active ? ST_LOAD : ST_HOLDOFF) :
                      bus.dl_active ? ST_LOAD :
                      (r_state == ST_HOLDOFF && r_hold_cnt == 16'd0) ? ST_RUN : r_state;
    end

    // State register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Holdoff timer, byte counter and the done/error status flags.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_hold_cnt <= '0;
            r_byte_cnt <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_hold_cnt <= w_hold_entry ? 16'(HOLDOFF_CYCLES - 1) :
                          (r_hold_cnt != 16'd0) ? r_hold_cnt - 16'd1 : r_hold_cnt;
            r_byte_cnt <= w_load_entry ? '0 : w_cnt_nxt;
            r_done     <= w_load_entry ? 1'b0 : w_run_entry ? 1'b1 : r_done;
            r_error    <= w_load_entry ? 1'b0 :
                          ((w_wr && w_oor) || (w_load_exit && w_cnt_nxt != EXPECTED_LEN)) ? 1'b1 : r_error;
        end
    end

    // Shared ROM port: CPU fetch address in RUN, registered download writes otherwise.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_sel   <= SEL_NONE;
            r_rd_ack    <= 1'b0;
        end else begin
            r_rd_ack <= (r_state == ST_RUN) && bus.cpu_rd_req && !bus.dl_active;
            if (r_state == ST_RUN) begin
                r_mem_addr <= {2'b00, bus.cpu_addr};
                r_mem_sel  <= SEL_PROG;
                r_mem_we   <= 1'b0;
            end else begin
                r_mem_we <= w_accept;
                if (w_accept) begin
                    r_mem_addr  <= w_rel;
                    r_mem_wdata <= bus.dl_data;
                    r_mem_sel   <= w_sel;
                end
            end
        end
    end

`ifdef DL_CHECKSUM_EN
    logic [7:0] r_sum;

    // Running byte sum of the current download, frozen outside LOAD.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_sum <= '0;
        else       r_sum <= w_load_entry ? 8'h00 : w_accept ? r_sum + bus.dl_data : r_sum;
    end

    assign bus.dl_sum = r_sum;
`else
    assign bus.dl_sum = 8'h00;
`endif

    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_sel    = r_mem_sel;
    assign bus.cpu_rd_ack = r_rd_ack;
    assign bus.cpu_hold   = r_state != ST_RUN;
    assign bus.core_reset = r_state != ST_RUN;
    assign bus.dl_done    = r_done;
    assign bus.dl_error   = r_error;

endmodule

// File: tb/tb_galaxian_dl_ctrl.sv
// tb_galaxian_dl_ctrl: scoreboard bench for the ROM download controller.
module tb_galaxian_dl_ctrl;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] addr;
        logic [7:0]  data;
        int          due;
    } wexp_t;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } rexp_t;

    logic  clk = 1'b0;
    logic  rst;
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_err = 0;
    int    n;
    wexp_t wq[$];
    rexp_t rq[$];

    galaxian_dl_ctrl_if bus();

    galaxian_dl_ctrl #(
        .HOLDOFF_CYCLES (16),
        .EXPECTED_LEN   (16'h5020)
    ) dut (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [18:0] region_of(input logic [15:0] a);
        if (a < 16'h4000)      return {3'b001, a};
        else if (a < 16'h5000) return {3'b010, a - 16'h4000};
        else                   return {3'b100, a - 16'h5000};
    endfunction

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input bit push);
        wexp_t       e;
        logic [18:0] m;
        bus.dl_wr   = 1'b1;
        bus.dl_addr = a;
        bus.dl_data = d;
        if (push) begin
            m      = region_of(a);
            e.sel  = m[18:16];
            e.addr = m[15:0];
            e.data = d;
            e.due  = cyc + 1;
            wq.push_back(e);
        end
        tick();
    endtask

    task automatic finish_dl(output int cnt);
        bus.dl_wr     = 1'b0;
        bus.dl_active = 1'b0;
        tick();
        cnt = 0;
        while (bus.core_reset && cnt < 64) begin
            tick();
            cnt++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_core_reset"}, bus.core_reset, 1);
        chk({tag, "_cpu_hold"}, bus.cpu_hold, 1);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_mem_sel"}, bus.mem_sel, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_cpu_rd_ack"}, bus.cpu_rd_ack, 0);
        chk({tag, "_dl_done"}, bus.dl_done, 0);
        chk({tag, "_dl_error"}, bus.dl_error, 0);
        chk({tag, "_dl_sum"}, bus.dl_sum, 0);
    endtask

    initial begin
        wexp_t e;
        rexp_t r;
        forever begin
            @(negedge clk);
            if (bus.mem_we === 1'b1) begin
                if (wq.size() == 0) chk("mem_we_unexpected", bus.mem_we, 0);
                else begin
                    e = wq.pop_front();
                    chk("mem_write", {32'(cyc), 5'd0, bus.mem_sel, bus.mem_addr, bus.mem_wdata},
                        {32'(e.due), 5'd0, e.sel, e.addr, e.data});
                end
            end
            if (bus.cpu_rd_ack === 1'b1) begin
                if (rq.size() == 0) chk("cpu_rd_ack_unexpected", bus.cpu_rd_ack, 0);
                else begin
                    r = rq.pop_front();
                    chk("cpu_read", {32'(cyc), 3'b001, bus.mem_sel, bus.mem_addr},
                        {32'(r.due), 3'b001, 3'b001, r.addr});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rexp_t r;
        logic [7:0] exp_sum;
        rst            = 1'b1;
        bus.dl_active  = 1'b0;
        bus.dl_wr      = 1'b0;
        bus.dl_addr    = '0;
        bus.dl_data    = '0;
        bus.cpu_rd_req = 1'b0;
        bus.cpu_addr   = '0;
        tick();
        chk_reset_vals("reset");
        tick();
        rst = 1'b0;
        tick();

        // Full image from IDLE.
        bus.dl_active = 1'b1;
        tick();
        chk("load_core_reset", bus.core_reset, 1);
        for (int a = 0; a < 'h5020; a++)
            wr(16'(a), 8'(a) ^ 8'(a >> 8) ^ 8'h5A, 1'b1);
        finish_dl(n);
        chk("full_holdoff_cycles", n, 16);
        chk("full_dl_done", bus.dl_done, 1);
        chk("full_dl_error", bus.dl_error, 0);
        chk("run_cpu_hold", bus.cpu_hold, 0);

        // Single CPU read in RUN.
        bus.cpu_rd_req = 1'b1;
        bus.cpu_addr   = 14'h1234;
        r.addr = 16'h1234;
        r.due  = cyc + 1;
        rq.push_back(r);
        tick();
        bus.cpu_rd_req = 1'b0;
        tick();

        // dl_active re-rises together with a CPU request: download wins.
        bus.dl_active  = 1'b1;
        bus.cpu_rd_req = 1'b1;
        bus.cpu_addr   = 14'h0777;
        tick();
        chk("rerise_core_reset", bus.core_reset, 1);
        chk("rerise_dl_done", bus.dl_done, 0);
        chk("rerise_no_ack", bus.cpu_rd_ack, 0);
        bus.cpu_rd_req = 1'b0;
        wr(16'h0001, 8'hFF, 1'b1);
        wr(16'h4010, 8'h02, 1'b1);
        wr(16'h5003, 8'h10, 1'b1);
`ifdef DL_CHECKSUM_EN
        exp_sum = 8'h11;
`else
        exp_sum = 8'h00;
`endif
        chk("dl_sum", bus.dl_sum, exp_sum);
        wr(16'h4005, 8'hA5, 1'b1);
        wr(16'h6000, 8'h3C, 1'b0);
        bus.dl_wr = 1'b0;
        chk("oor_no_mem_we", bus.mem_we, 0);
        chk("oor_dl_error", bus.dl_error, 1);

        // CPU request held through HOLDOFF is served once RUN begins.
        bus.cpu_rd_req = 1'b1;
        bus.cpu_addr   = 14'h1234;
        bus.dl_active  = 1'b0;
        tick();
        n = 0;
        while (bus.core_reset && n < 64) begin
            chk("holdoff_cpu_hold", bus.cpu_hold, 1);
            chk("holdoff_no_ack", bus.cpu_rd_ack, 0);
            tick();
            n++;
        end
        chk("short_holdoff_cycles", n, 16);
        chk("short_dl_done", bus.dl_done, 1);
        chk("short_dl_error", bus.dl_error, 1);
        r.addr = 16'h1234;
        r.due  = cyc + 1;
        rq.push_back(r);
        tick();
        bus.cpu_rd_req = 1'b0;
        tick();

        // 0x5000-byte image is one palette short.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.dl_active = 1'b1;
        tick();
        for (int a = 0; a < 'h5000; a++)
            wr(16'(a), 8'(a * 3), 1'b1);
        finish_dl(n);
        chk("short_img_holdoff", n, 16);
        chk("short_img_dl_error", bus.dl_error, 1);
        chk("short_img_dl_done", bus.dl_done, 1);

        // Reset in the middle of LOAD drops the write still in flight.
        bus.dl_active = 1'b1;
        tick();
        wr(16'h0100, 8'h11, 1'b1);
        wr(16'h4100, 8'h22, 1'b1);
        bus.dl_addr = 16'h5001;
        bus.dl_data = 8'h33;
        #5;
        rst           = 1'b1;
        bus.dl_active = 1'b0;
        bus.dl_wr     = 1'b0;
        #1;
        chk_reset_vals("midload_reset");
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk_reset_vals("post_reset_idle");

        chk("wr_queue_drained", wq.size(), 0);
        chk("rd_queue_drained", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
